// File: rtl/ex_muldiv_if.sv
// EX-stage multiply/divide unit bus: op and operands in; stall, valid, result out.
interface ex_muldiv_if;
  logic        flush;
  logic [4:0]  ex_alu_opt;
  logic [31:0] ex_rs1_data;
  logic [31:0] ex_rs2_data;
  logic        md_pause;
  logic        md_valid;
  logic [31:0] md_result;

  // Pipeline side
  modport master (
    output flush, ex_alu_opt, ex_rs1_data, ex_rs2_data,
    input  md_pause, md_valid, md_result
  );

  // Mul/div unit side
  modport slave (
    input  flush, ex_alu_opt, ex_rs1_data, ex_rs2_data,
    output md_pause, md_valid, md_result
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle on operand
// magnitudes, sign fix-up on completion, 1-cycle fast path for div-by-zero/overflow.
module ex_muldiv (
  input logic        clk,
  input logic        rst,
  ex_muldiv_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;     // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [31:0] opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [2:0]  op_q, op_d;
  logic        neg_q, neg_d;     // negate the selected result at completion
  logic [31:0] result_q, result_d;

  logic        is_mop;
  logic [2:0]  op_in;
  logic        signed_a, signed_b, sign_a, sign_b, neg_in;
  logic [31:0] a_mag, b_mag;
  logic        special;
  logic [31:0] spec_res;
  logic [63:0] mul_step, div_step, acc_step;
  logic [32:0] mul_sum;
  logic [32:0] div_top;
  logic [31:0] div_sub;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix, final_res;

  assign is_mop = (bus.ex_alu_opt[4:3] == 2'b10);
  assign op_in  = bus.ex_alu_opt[2:0];

  // Operand decode at capture: signedness, magnitudes, result sign and special cases
  always_comb begin
    signed_a = op_in[2] ? ~op_in[0] : (op_in[1:0] != 2'b11);
    signed_b = op_in[2] ? ~op_in[0] : ~op_in[1];
    sign_a   = signed_a & bus.ex_rs1_data[31];
    sign_b   = signed_b & bus.ex_rs2_data[31];
    a_mag    = sign_a ? (32'd0 - bus.ex_rs1_data) : bus.ex_rs1_data;
    b_mag    = sign_b ? (32'd0 - bus.ex_rs2_data) : bus.ex_rs2_data;
    // REM/REMU follow the dividend; everything else follows the sign mismatch
    neg_in   = (op_in[2] && op_in[1]) ? sign_a : (sign_a ^ sign_b);
    special  = 1'b0;
    spec_res = 32'd0;
    if (op_in[2]) begin
      if (bus.ex_rs2_data == 32'd0) begin
        special  = 1'b1;
        spec_res = op_in[1] ? bus.ex_rs1_data : 32'hFFFF_FFFF;
      end else if (!op_in[0] && bus.ex_rs1_data == 32'h8000_0000 &&
                   bus.ex_rs2_data == 32'hFFFF_FFFF) begin
        special  = 1'b1;
        spec_res = op_in[1] ? 32'd0 : 32'h8000_0000;
      end
    end
  end

  // One iteration: shift-add multiply or restoring shift-subtract divide
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_step = {mul_sum, acc_q[31:1]};
    div_top  = acc_q[63:31];
    div_sub  = acc_q[62:31] - opnd_q;
    div_step = (div_top >= {1'b0, opnd_q}) ? {div_sub, acc_q[30:0], 1'b1}
                                           : {acc_q[62:0], 1'b0};
    acc_step = op_q[2] ? div_step : mul_step;
  end

  // Sign correction and result select from the final iteration
  always_comb begin
    prod_fix = neg_q ? (64'd0 - acc_step) : acc_step;
    quo_fix  = neg_q ? (32'd0 - acc_step[31:0]) : acc_step[31:0];
    rem_fix  = neg_q ? (32'd0 - acc_step[63:32]) : acc_step[63:32];
    unique case (op_q)
      3'd0:                final_res = prod_fix[31:0];
      3'd1, 3'd2, 3'd3:    final_res = prod_fix[63:32];
      3'd4, 3'd5:          final_res = quo_fix;
      default:             final_res = rem_fix;
    endcase
  end

  // Next-state: start/fast-path in idle, iterate in busy, flush wins over everything
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    op_d     = op_q;
    neg_d    = neg_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (!bus.flush && is_mop) begin
          if (special) begin
            result_d = spec_res;
            state_d  = StDone;
          end else begin
            acc_d   = {32'd0, op_in[2] ? a_mag : b_mag};
            opnd_d  = op_in[2] ? b_mag : a_mag;
            op_d    = op_in;
            neg_d   = neg_in;
            cnt_d   = 5'd0;
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            result_d = final_res;
            state_d  = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= 5'd0;
      acc_q    <= 64'd0;
      opnd_q   <= 32'd0;
      op_q     <= 3'd0;
      neg_q    <= 1'b0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  // Stall holds the M-op in EX until the result cycle
  assign bus.md_pause  = is_mop && (state_q == StIdle || state_q == StBusy);
  assign bus.md_valid  = (state_q == StDone);
  assign bus.md_result = result_q;

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock.
REQ-002 SHALL have port: rst  input  1  reset, active-low, asynchronous.
REQ-003 SHALL have port: flush  input  1  kill the in-flight EX instruction.
REQ-004 SHALL have port: ex_alu_opt  input  5  EX-stage operation code from the ID/EX register.
REQ-005 SHALL have port: ex_rs1_data  input  32  operand A.
REQ-006 SHALL have port: ex_rs2_data  input  32  operand B.
REQ-007 SHALL have port: md_pause  output  1  stall request to the upstream pipeline registers.
REQ-008 SHALL have port: md_valid  output  1  result valid, one-cycle pulse.
REQ-009 SHALL have port: md_result  output  32  mul/div result.
REQ-010 SHALL use M-op encodings: MUL=16, MULH=17, MULHSU=18, MULHU=19, DIV=20, DIVU=21, REM=22, REMU=23; all other ex_alu_opt values are non-M.

Function
REQ-011 SHALL implement states IDLE, BUSY, DONE, with a 5-bit iteration counter cnt.
REQ-012 IDLE with an M-op present, normal case: capture operands, op and sign info at the clock edge; go to BUSY with cnt=0.
REQ-013 IDLE with an M-op present, special case: go directly to DONE with the precomputed result. Special cases are divisor==0, and signed DIV/REM of 0x80000000 by 0xFFFFFFFF.
REQ-014 BUSY SHALL perform one radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide, on operand magnitudes.
REQ-015 BUSY SHALL go to DONE at the edge where cnt==31, after exactly 32 iterations.
REQ-016 DONE SHALL drive md_valid=1 and the final result, and go to IDLE at the next edge.
REQ-017 md_pause SHALL be combinational, =1 when an M-op is on ex_alu_opt and state is IDLE or BUSY; else 0.
REQ-018 Normal-case pause SHALL last exactly 33 cycles; special-case pause SHALL last exactly 1 cycle.
REQ-019 Signed operands SHALL be converted to magnitudes at capture:
- MULH: both operands signed.
- MULHSU: rs1 signed, rs2 unsigned.
- MUL, DIV, REM: signed.
REQ-020 Product sign correction SHALL negate the 64-bit product when the operand signs differ.
REQ-021 Multiply result select: MUL = product[31:0]; MULH, MULHSU, MULHU = product[63:32].
REQ-022 Divide sign rules:
- DIV quotient is negated when the operand signs differ.
- REM remainder takes the sign of the dividend.
- DIVU/REMU use no sign correction.
REQ-023 Divide by zero: quotient = 0xFFFFFFFF; remainder = dividend.
REQ-024 Signed overflow (0x80000000 / -1): quotient = 0x80000000; remainder = 0.
REQ-025 md_result SHALL be registered and hold its value until the next DONE.
REQ-026 flush=1 SHALL force IDLE at the next edge from any state, with md_valid=0 in the following cycle. flush takes priority over start and completion.
REQ-027 An M-op present in the cycle after DONE (back-to-back) SHALL start a new operation from IDLE normally.
REQ-028 Non-M ops SHALL never change state, and SHALL give md_pause=0 and md_valid=0.

Reset
REQ-029 rst=0 SHALL immediately force state=IDLE, cnt=0, md_valid=0, md_result=0, and all internal operand/accumulator registers to 0, independent of clk.
REQ-030 With rst=0, md_pause SHALL still follow REQ-017, which gives 1 whenever an M-op is present.
REQ-031 Deassertion of rst SHALL allow a start on the first rising edge at which rst=1.
REQ-032 Reset asserted mid-BUSY SHALL abandon the operation with no md_valid pulse.

Verification
REQ-033 MUL 7 x 0xFFFFFFFD -> md_pause high 33 cycles, then md_valid pulse, md_result=0xFFFFFFEB.
REQ-034 0xFFFFFFFF x 0xFFFFFFFF -> MULHU 0xFFFFFFFE; MULH 0x00000000; MULHSU 0xFFFFFFFF.
REQ-035 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
REQ-036 Special cases, each with a 1-cycle pause:
- DIVU 5/0 -> 0xFFFFFFFF.
- REM 5/0 -> 5.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
- REM 0x80000000/0xFFFFFFFF -> 0.
REQ-037 flush at BUSY cnt=10 -> IDLE next edge, no md_valid; a following MUL 3x4 yields 12 after 33 pause cycles.
REQ-038 rst low at BUSY cnt=20 -> md_result=0 and md_valid=0 immediately; back-to-back MUL then DIVU both complete correctly; a non-M op gives md_pause=0.
